// File: rtl/isoiec7816_pkg.sv
// Shared definitions for the ISO/IEC 7816 card-side transmit path:
// character width and transmit-controller state encoding.
package isoiec7816_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/isoiec7816_fifo.sv
// Character queue for the card transmit controller. Storage is written
// synchronously, the head is read combinationally so the controller can
// register it on the load edge. A pop and a push may share a cycle even
// when the queue is full; the freed head slot takes the new byte.
module isoiec7816_fifo
    import isoiec7816_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [CHAR_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [CHAR_W-1:0]     head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [CHAR_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic                   pop;
    logic                   push;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A flush wins over everything; a full queue only accepts when it pops.
    assign pop  = rd_en && !empty && !flush;
    assign push = wr_en && !flush && (!full || pop);

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/isoiec7816_card_tx_ctrl.sv
// Card transmit controller: queues characters and hands them one at a
// time to the character engine, inserting a programmable idle gap after
// each one. The queued count includes the character currently in flight;
// it is only popped when the engine reports it transmitted.
module isoiec7816_card_tx_ctrl
    import isoiec7816_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  enable,
    input  logic                  card_rst,
    input  logic [7:0]            gap,
    input  logic [CHAR_W-1:0]     wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [CHAR_W-1:0]     char_tx,
    output logic                  char_tx_load,
    input  logic                  char_tx_transmitted,
    output logic                  tx_done
);

    localparam logic [DEPTH_LOG2:0] ONE_CNT = (DEPTH_LOG2 + 1)'(1);

    tx_state_t          state;
    logic [7:0]         gap_cnt;
    logic [CHAR_W-1:0]  head;
    logic               pop;
    logic               flush;

    // Card reset held low empties the queue and parks the controller.
    assign flush = !card_rst;
    // Transmitted pulses only matter while a character is outstanding.
    assign pop   = (state == ST_SEND) && char_tx_transmitted && card_rst;

    isoiec7816_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clock_in),
        .rst      (reset_in),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    // Transmit sequencing: load head, wait for completion, idle for gap.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state        <= ST_IDLE;
            gap_cnt      <= 8'd0;
            char_tx      <= '0;
            char_tx_load <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!card_rst) begin
                state        <= ST_IDLE;
                gap_cnt      <= 8'd0;
                char_tx_load <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (enable && !empty) begin
                            char_tx      <= head;
                            char_tx_load <= 1'b1;
                            state        <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (char_tx_transmitted) begin
                            char_tx_load <= 1'b0;
                            // Last character leaves only if no write refills the queue.
                            tx_done      <= (count == ONE_CNT) && !wr_en;
                            if (gap != 8'd0) begin
                                gap_cnt <= gap;
                                state   <= ST_GAP;
                            end else begin
                                state   <= ST_IDLE;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt <= 8'd1) begin
                            gap_cnt <= 8'd0;
                            state   <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_isoiec7816_card_tx_ctrl.sv
// Directed bench for the card transmit controller: a vector table for the
// basic cycle-by-cycle flow plus sequences for multi-cycle corner cases.
module tb_isoiec7816_card_tx_ctrl;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        enable;
    logic        card_rst;
    logic [7:0]  gap;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  char_tx;
    logic        char_tx_load;
    logic        char_tx_transmitted;
    logic        tx_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    isoiec7816_card_tx_ctrl #(.DEPTH_LOG2(4)) dut (
        .clock_in            (clock_in),
        .reset_in            (reset_in),
        .enable              (enable),
        .card_rst            (card_rst),
        .gap                 (gap),
        .wr_data             (wr_data),
        .wr_en               (wr_en),
        .full                (full),
        .empty               (empty),
        .count               (count),
        .overflow            (overflow),
        .char_tx             (char_tx),
        .char_tx_load        (char_tx_load),
        .char_tx_transmitted (char_tx_transmitted),
        .tx_done             (tx_done)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic        wr_en;
        logic [7:0]  wr_data;
        logic        transmitted;
        logic        exp_load;
        logic [7:0]  exp_char;
        logic [4:0]  exp_count;
        logic        exp_empty;
        logic        exp_done;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
        if (tx_done) done_cnt++;
    endtask

    task automatic write_char(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_tx();
        char_tx_transmitted = 1'b1;
        tick();
        char_tx_transmitted = 1'b0;
    endtask

    task automatic wait_load(input string name);
        int n = 0;
        while (!char_tx_load && n < 200) begin
            tick();
            n++;
        end
        if (!char_tx_load) chk({name, "_timeout"}, {31'd0, char_tx_load}, 32'd1);
    endtask

    initial begin
        logic [7:0] got [3];
        logic [7:0] expc;
        int n;
        int snap;

        reset_in = 1'b1;
        enable = 1'b0;
        card_rst = 1'b1;
        gap = 8'd0;
        wr_data = 8'h00;
        wr_en = 1'b0;
        char_tx_transmitted = 1'b0;

        // Vector table: gap=0, enable=1
        vecs[0] = '{1'b1, 8'h3B, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h10, 1'b0, 1'b1, 8'h3B, 5'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h94, 1'b0, 1'b1, 8'h3B, 5'd3, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3B, 5'd3, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3B, 5'd2, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 5'd2, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 5'd1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h94, 5'd1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h94, 5'd0, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h94, 5'd0, 1'b1, 1'b0};

        repeat (2) @(posedge clock_in);
        #1;
        chk("reset_state", {char_tx, char_tx_load, tx_done, count, empty, full, overflow},
            {8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0});
        reset_in = 1'b0;
        enable = 1'b1;
        tick();
        chk("post_reset_idle", {char_tx_load, count}, {1'b0, 5'd0});

        for (int i = 0; i < 10; i++) begin
            wr_en = vecs[i].wr_en;
            wr_data = vecs[i].wr_data;
            char_tx_transmitted = vecs[i].transmitted;
            tick();
            chk($sformatf("vec%0d", i), {char_tx_load, char_tx, count, empty, tx_done},
                {vecs[i].exp_load, vecs[i].exp_char, vecs[i].exp_count, vecs[i].exp_empty, vecs[i].exp_done});
        end
        wr_en = 1'b0;
        char_tx_transmitted = 1'b0;

        // Three characters, transmitted 20 cycles after each load
        done_cnt = 0;
        write_char(8'h3B);
        write_char(8'h10);
        write_char(8'h94);
        for (int i = 0; i < 3; i++) begin
            wait_load("seq3_load");
            got[i] = char_tx;
            repeat (19) tick();
            chk("seq3_stable", {char_tx_load, char_tx}, {1'b1, got[i]});
            pulse_tx();
        end
        chk("seq3_c0", got[0], 8'h3B);
        chk("seq3_c1", got[1], 8'h10);
        chk("seq3_c2", got[2], 8'h94);
        chk("seq3_done", done_cnt, 1);
        chk("seq3_empty", empty, 1);

        // Gap of 5 between two characters
        gap = 8'd5;
        write_char(8'hE1);
        write_char(8'hE2);
        wait_load("gap_load1");
        pulse_tx();
        n = 0;
        while (!char_tx_load && n < 50) begin
            tick();
            n++;
        end
        chk("gap_low_cycles", n, 6);
        chk("gap_char2", char_tx, 8'hE2);
        gap = 8'd0;
        pulse_tx();
        chk("gap_empty", empty, 1);

        // Enable dropped mid-send
        write_char(8'hC1);
        write_char(8'hC2);
        wait_load("en_load1");
        enable = 1'b0;
        repeat (3) tick();
        chk("en_hold", {char_tx_load, char_tx}, {1'b1, 8'hC1});
        pulse_tx();
        repeat (5) tick();
        chk("en_parked", {char_tx_load, count}, {1'b0, 5'd1});
        enable = 1'b1;
        tick();
        chk("en_resume", {char_tx_load, char_tx}, {1'b1, 8'hC2});
        pulse_tx();
        chk("en_empty", empty, 1);

        // Card reset mid-send with four queued, write during flush dropped
        for (int i = 0; i < 4; i++) write_char(8'(8'hD0 + i));
        wait_load("crst_load");
        snap = done_cnt;
        card_rst = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h77;
        tick();
        card_rst = 1'b1;
        wr_en = 1'b0;
        chk("crst_flush", {char_tx_load, count, empty}, {1'b0, 5'd0, 1'b1});
        chk("crst_no_done", done_cnt, snap);
        tick();
        chk("crst_stays_idle", {char_tx_load, count}, {1'b0, 5'd0});

        // 17 writes with enable=0
        enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            write_char(8'(8'h40 + i));
            if (i == 15) chk("fill_full16", {full, count, overflow}, {1'b1, 5'd16, 1'b0});
        end
        chk("fill_overflow", {full, count, overflow}, {1'b1, 5'd16, 1'b1});
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_load("fill_load");
            chk($sformatf("fill_char%0d", i), char_tx, 8'(8'h40 + i));
            pulse_tx();
        end
        chk("fill_drained", {empty, overflow}, {1'b1, 1'b1});
        card_rst = 1'b0;
        tick();
        card_rst = 1'b1;
        chk("ovf_cleared", overflow, 0);

        // Full queue, write coincident with transmitted
        enable = 1'b0;
        for (int i = 0; i < 16; i++) write_char(8'(8'h60 + i));
        enable = 1'b1;
        wait_load("fullwr_load");
        chk("fullwr_head", char_tx, 8'h60);
        wr_en = 1'b1;
        wr_data = 8'hA5;
        char_tx_transmitted = 1'b1;
        tick();
        wr_en = 1'b0;
        char_tx_transmitted = 1'b0;
        chk("fullwr_count", {count, full, overflow}, {5'd16, 1'b1, 1'b0});
        for (int i = 0; i < 16; i++) begin
            wait_load("fullwr_drain");
            expc = (i < 15) ? 8'(8'h61 + i) : 8'hA5;
            chk($sformatf("fullwr_char%0d", i), char_tx, expc);
            pulse_tx();
        end
        chk("fullwr_empty", empty, 1);

        // Asynchronous reset mid-send
        write_char(8'hF0);
        wait_load("arst_load");
        #2;
        reset_in = 1'b1;
        #1;
        chk("arst_async", {char_tx, char_tx_load, count, empty}, {8'h00, 1'b0, 5'd0, 1'b1});
        tick();
        reset_in = 1'b0;
        tick();
        chk("arst_release", {char_tx_load, count}, {1'b0, 5'd0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
